// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory target for the core load/store port. Accepts one
//            request at a time, performs RV32I byte/half/word loads and
//            stores on little-endian lanes, and answers with a single-cycle
//            response strobe after WAIT_CYCLES wait states. Misaligned,
//            out-of-range and illegal-width accesses are flagged, never
//            committed.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_DEPTH    = 32'(DEPTH_WORDS);
    localparam bit          c_HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [3:0]  c_WAIT_M1  = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_cnt;
    logic [3:0]         w_next_cnt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [2:0]         r_f3;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_cur_we;
    logic [31:0]        w_cur_addr;
    logic [2:0]         w_cur_f3;
    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;
    logic               w_wr_en;
    logic [3:0]         w_be;
    logic [31:0]        w_lane_data;

    assign req_ready = (r_state == c_S_IDLE);
    assign w_accept  = req_valid && req_ready;

    // In IDLE the live request is decoded (store commit, zero-wait load);
    // afterwards the captured copy is used, since req_* are don't-care then.
    assign w_cur_we   = (r_state == c_S_IDLE) ? req_we     : r_we;
    assign w_cur_addr = (r_state == c_S_IDLE) ? req_addr   : r_addr;
    assign w_cur_f3   = (r_state == c_S_IDLE) ? req_funct3 : r_f3;
    assign w_idx      = w_cur_addr[2 +: c_IDX_W];

    // Legality: width encoding, store-only-signed rule, alignment, range.
    always_comb begin
        w_err = 1'b0;
        case (w_cur_f3)
            3'b000:  w_err = 1'b0;
            3'b001:  w_err = w_cur_addr[0];
            3'b010:  w_err = |w_cur_addr[1:0];
            3'b100:  w_err = w_cur_we;
            3'b101:  w_err = w_cur_we | w_cur_addr[0];
            default: w_err = 1'b1;
        endcase
        if ({2'b00, w_cur_addr[31:2]} >= c_DEPTH) begin
            w_err = 1'b1;
        end
    end

    // Store byte enables and lane-replicated data for the selected width.
    always_comb begin
        w_be        = 4'b0000;
        w_lane_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = req_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_lane_data = req_wdata;
            end
        endcase
    end

    assign w_wr_en = rst_n && w_accept && req_we && !w_err;

    // Commit legal stores at the acceptance edge; the array has no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
                end
            end
        end
    end

    // Lane select and sign/zero extension of the addressed word.
    always_comb begin
        w_word = r_mem[w_idx];
        w_byte = w_word[{w_cur_addr[1:0], 3'b000} +: 8];
        w_half = w_cur_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load = 32'd0;
        case (w_cur_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // Next state and wait counter.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (c_HAS_WAIT) begin
                        w_next_state = c_S_WAIT;
                        w_next_cnt   = c_WAIT_M1;
                    end else begin
                        w_next_state = c_S_RESP;
                    end
                end
            end
            c_S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = c_S_RESP;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next_state == c_S_RESP) && (r_state != c_S_RESP);

    // State, request capture and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_f3      <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_we   <= req_we;
                r_addr <= req_addr;
                r_f3   <= req_funct3;
            end
            if (w_enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= w_err;
                rsp_rdata <= (w_err || w_cur_we) ? 32'd0 : w_load;
            end else if (r_state == c_S_RESP) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder: three instances with
//            WAIT_CYCLES 1, 0 and 3 share the request fields; each has its
//            own valid and response signals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld   [3];
    logic        rdy   [3];
    logic        rv    [3];
    logic        rerr  [3];
    logic [31:0] rdata [3];
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;

    int errors = 0;
    int checks = 0;

    // Behavioural byte-addressed memory for instance 0 plus written flags.
    logic [7:0] m_mem [4*DEPTH];
    bit         m_ok  [4*DEPTH];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_funct3(f3),
        .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .rsp_err(rerr[0]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_funct3(f3),
        .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .rsp_err(rerr[1]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_funct3(f3),
        .rsp_valid(rv[2]), .rsp_rdata(rdata[2]), .rsp_err(rerr[2]));

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference access: decides legality from the access rules, updates the
    // byte model on legal stores, and assembles/extends load data.
    function automatic void ref_access(input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input logic [2:0] f,
                                       output logic err, output logic [31:0] rd,
                                       output logic known);
        int     size;
        bit     sgn;
        longint val;
        longint a_l;
        size  = 1;
        sgn   = 0;
        err   = 1'b0;
        rd    = 32'd0;
        known = 1'b1;
        a_l   = longint'(a);
        case (f)
            3'd0:    begin size = 1; sgn = 1; end
            3'd1:    begin size = 2; sgn = 1; end
            3'd2:    size = 4;
            3'd4:    size = 1;
            3'd5:    size = 2;
            default: err = 1'b1;
        endcase
        if (w && f >= 3'd4) err = 1'b1;
        if ((a_l % size) != 0) err = 1'b1;
        if (a_l >= 4 * DEPTH) err = 1'b1;
        if (err) return;
        if (w) begin
            for (int i = 0; i < size; i++) begin
                m_mem[int'(a_l) + i] = 8'(d >> (8 * i));
                m_ok[int'(a_l) + i]  = 1'b1;
            end
        end else begin
            val = 0;
            for (int i = 0; i < size; i++) begin
                val   = val + (longint'(m_mem[int'(a_l) + i]) << (8 * i));
                known = known & m_ok[int'(a_l) + i];
            end
            if (sgn && val >= (64'sd1 << (8 * size - 1))) val = val - (64'sd1 << (8 * size));
            rd = val[31:0];
        end
    endfunction

    // One request on instance k; returns response data, error flag and the
    // latency counted in cycles including the acceptance cycle.
    task automatic xact(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        we = w; addr = a; wdata = d; f3 = f; vld[k] = 1'b1;
        n = 0;
        while (!rdy[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[k]) begin
            chk("ready timeout", 32'(rdy[k]), 32'd1);
            vld[k] = 1'b0; rd = 32'd0; e = 1'b1; lat = -1;
            return;
        end
        @(negedge clk);
        // The request was taken at the edge just passed; scramble the fields.
        vld[k] = 1'b0; we = 1'($urandom); addr = $urandom; wdata = $urandom; f3 = 3'($urandom);
        n = 0;
        while (!rv[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rv[k]) chk("response timeout", 32'(rv[k]), 32'd1);
        lat = n + 1;
        rd  = rdata[k];
        e   = rerr[k];
        @(negedge clk);
        chk("single pulse", 32'(rv[k]), 32'd0);
    endtask

    // req_valid held high: check acceptance spacing and response placement.
    task automatic cont_test(input int k);
        int acc_t[$];
        int rsp_t[$];
        int w;
        logic prev_rv;
        w = wait_of(k);
        prev_rv = 1'b0;
        @(negedge clk);
        we = 1'b1; addr = 32'h4; wdata = 32'h0BADF00D; f3 = 3'b010; vld[k] = 1'b1;
        for (int t = 0; t < 24; t++) begin
            if (rdy[k]) acc_t.push_back(t);
            if (rv[k]) begin
                rsp_t.push_back(t);
                chk("cont pulse width", 32'(prev_rv), 32'd0);
                chk("cont ready low in resp", 32'(rdy[k]), 32'd0);
            end
            prev_rv = rv[k];
            @(negedge clk);
        end
        vld[k] = 1'b0;
        chk("cont accept count", 32'(acc_t.size() >= 3), 32'd1);
        chk("cont resp count", 32'(rsp_t.size() + 1 >= acc_t.size()), 32'd1);
        for (int i = 0; i + 1 < acc_t.size(); i++)
            chk("cont accept spacing", 32'(acc_t[i+1] - acc_t[i]), 32'(2 + w));
        for (int i = 0; i < rsp_t.size() && i < acc_t.size(); i++)
            chk("cont resp offset", 32'(rsp_t[i] - acc_t[i]), 32'(1 + w));
        repeat (10) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, input logic [31:0] er, input logic ee);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.f = f; v.exp_rd = er; v.exp_err = ee;
        return v;
    endfunction

    initial begin
        vec_t        tab[$];
        logic [31:0] rd, e_rd;
        logic        e, e_err, known;
        int          lat, cnt, r;
        logic        w;
        logic [31:0] a, d;
        logic [2:0]  f;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) vld[k] = 1'b0;
        we = 1'b0; addr = 32'd0; wdata = 32'd0; f3 = 3'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset ready", 32'(rdy[0]), 32'd1);
        chk("reset rsp_valid", 32'(rv[0]), 32'd0);
        chk("reset rsp_rdata", rdata[0], 32'd0);
        chk("reset rsp_err", 32'(rerr[0]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table on the WAIT_CYCLES=1 instance.
        tab.push_back(mk(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0));
        tab.push_back(mk(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0));
        tab.push_back(mk(1, 32'h20, 32'h00000000, 3'b010, 32'h0, 0));
        tab.push_back(mk(1, 32'h23, 32'hFFFFFF80, 3'b000, 32'h0, 0));
        tab.push_back(mk(1, 32'h20, 32'hABCD1234, 3'b001, 32'h0, 0));
        tab.push_back(mk(0, 32'h20, 32'h0, 3'b010, 32'h80001234, 0));
        tab.push_back(mk(0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 0));
        tab.push_back(mk(0, 32'h23, 32'h0, 3'b100, 32'h00000080, 0));
        tab.push_back(mk(0, 32'h20, 32'h0, 3'b001, 32'h00001234, 0));
        tab.push_back(mk(1, 32'h42, 32'h00008001, 3'b001, 32'h0, 0));
        tab.push_back(mk(0, 32'h42, 32'h0, 3'b001, 32'hFFFF8001, 0));
        tab.push_back(mk(0, 32'h42, 32'h0, 3'b101, 32'h00008001, 0));
        tab.push_back(mk(1, 32'h21, 32'h11111111, 3'b010, 32'h0, 1));
        tab.push_back(mk(0, 32'h23, 32'h0, 3'b001, 32'h0, 1));
        tab.push_back(mk(0, 32'h20, 32'h0, 3'b011, 32'h0, 1));
        tab.push_back(mk(1, 32'h20, 32'h22222222, 3'b100, 32'h0, 1));
        tab.push_back(mk(0, 32'(4 * DEPTH), 32'h0, 3'b010, 32'h0, 1));
        tab.push_back(mk(0, 32'h20, 32'h0, 3'b010, 32'h80001234, 0));
        tab.push_back(mk(1, 32'(4 * DEPTH - 4), 32'h12345678, 3'b010, 32'h0, 0));
        tab.push_back(mk(0, 32'(4 * DEPTH - 4), 32'h0, 3'b010, 32'h12345678, 0));
        tab.push_back(mk(0, 32'(4 * DEPTH - 1), 32'h0, 3'b100, 32'h00000012, 0));
        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].w) ref_access(1'b1, tab[i].a, tab[i].d, tab[i].f, e_err, e_rd, known);
            xact(0, tab[i].w, tab[i].a, tab[i].d, tab[i].f, rd, e, lat);
            chk($sformatf("vec%0d rdata", i), rd, tab[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(e), 32'(tab[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
        end

        // Prefill a window, then random traffic against the byte model.
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            ref_access(1'b1, 32'h200 + 32'(4 * i), d, 3'b010, e_err, e_rd, known);
            xact(0, 1'b1, 32'h200 + 32'(4 * i), d, 3'b010, rd, e, lat);
            chk("prefill err", 32'(e), 32'd0);
        end
        for (int n = 0; n < 160; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85)      a = 32'h200 + 32'($urandom_range(0, 63));
            else if (r < 95) a = 32'(4 * DEPTH - 16) + 32'($urandom_range(0, 31));
            else             a = $urandom;
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            d = $urandom;
            ref_access(w, a, d, f, e_err, e_rd, known);
            xact(0, w, a, d, f, rd, e, lat);
            chk($sformatf("rand%0d err a=%h f=%0d we=%0b", n, a, f, w), 32'(e), 32'(e_err));
            if (known) chk($sformatf("rand%0d rdata a=%h f=%0d we=%0b", n, a, f, w), rd, e_rd);
        end

        // Latency of the other two instances, then continuous-valid throughput.
        xact(1, 1'b1, 32'h30, 32'h5A5A5A5A, 3'b010, rd, e, lat);
        chk("w0 store latency", 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h31, 32'h0, 3'b100, rd, e, lat);
        chk("w0 LBU rdata", rd, 32'h0000005A);
        xact(2, 1'b0, 32'h23, 32'h0, 3'b010, rd, e, lat);
        chk("w3 misaligned err", 32'(e), 32'd1);
        chk("w3 latency", 32'(lat), 32'd4);
        cont_test(1);
        cont_test(2);

        // Reset one cycle into the wait of a store on the WAIT_CYCLES=3 unit.
        @(negedge clk);
        we = 1'b1; addr = 32'h8; wdata = 32'hCAFEF00D; f3 = 3'b010; vld[2] = 1'b1;
        @(posedge clk);
        #1 vld[2] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset rsp_valid", 32'(rv[2]), 32'd0);
        chk("midreset ready", 32'(rdy[2]), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (rv[2]) cnt++;
        end
        chk("midreset dropped response", 32'(cnt), 32'd0);
        chk("midreset ready after", 32'(rdy[2]), 32'd1);
        xact(2, 1'b0, 32'h8, 32'h0, 3'b010, rd, e, lat);
        chk("store before reset kept", rd, 32'hCAFEF00D);
        chk("store before reset err", 32'(e), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
